thermo_decoder: RTL and testbench
=================================

THERMO_DECODER -- requirements
Module: thermo_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning number of thermometer input bits.
REQ-002 SHALL have derived localparam CW = $clog2(WIDTH+1), default 5, meaning binary code width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  thermometer word offered.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port thermo_in  input  WIDTH  thermometer word, bit0 = lowest level.
REQ-008 SHALL have port out_valid  output  1  decoded result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port code  output  CW  number of asserted levels, 0..WIDTH.
REQ-011 SHALL have port bubble_err  output  1  result's source word was not a clean thermometer code.
REQ-012 SHALL have port err_count  output  8  saturating count of results with bubble_err=1.
REQ-013 SHALL have port clr_err  input  1  synchronous clear of err_count.

Function
REQ-014 SHALL transfer input when in_valid && in_ready and output when out_valid && out_ready.
REQ-015 SHALL be a two-stage pipeline: S1 registers corrected word + error bit; S2 registers code, bubble_err.
REQ-016 SHALL produce first result on out_valid two cycles after acceptance, with out_ready held high.
REQ-017 SHALL sustain one result per cycle while out_ready=1.
REQ-018 SHALL deassert in_ready only when S1 and S2 both hold data and out_ready=0 (full pipeline stall).
REQ-019 SHALL hold code, bubble_err, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL perform bubble correction per bit: corrected[i] = majority(raw[i-1], raw[i], raw[i+1]), raw[-1]=1, raw[WIDTH]=0.
REQ-021 SHALL compute code as popcount of corrected word, range 0..WIDTH, no overflow.
REQ-022 SHALL set S1 error bit when raw word differs from any clean code (any 0 below a 1).
REQ-023 SHALL increment err_count on each output transfer with bubble_err=1, saturating at 255.
REQ-024 SHALL give clr_err priority over simultaneous increment (result 0).
REQ-025 SHALL keep all-zero input -> code 0, all-ones input -> code WIDTH, bubble_err=0 both.

Reset
REQ-026 SHALL on rst_n=0 clear S1/S2 valid flags, code=0, bubble_err=0, err_count=0, out_valid=0.
REQ-027 SHALL drive in_ready=1 during reset and in the first cycle after release.
REQ-028 SHALL discard in-flight words when reset asserts mid-operation; no result emitted for them.

Configuration
REQ-029 SHALL support macro THERMO_DEC_BUBBLE_FIX_EN.
REQ-030 SHALL with THERMO_DEC_BUBBLE_FIX_EN defined apply REQ-020 correction before popcount.
REQ-031 SHALL without it popcount the raw word; bubble_err detection and err_count unchanged.

Structure
REQ-032 SHALL take WIDTH default and CW derivation from shared package thermo_pkg, also used by the encoder side.
REQ-033 SHALL place result struct type (code, bubble_err) in thermo_pkg.
REQ-034 SHALL implement correction + error detection in sub-module thermo_bubble_filter (combinational, WIDTH-parameterised).

Verification
REQ-035 SHALL test: thermo_in=16'h00FF, out_ready=1 -> code=8, bubble_err=0, out_valid 2 cycles later.
REQ-036 SHALL test: thermo_in=16'h00F7 -> with FIX_EN code=8, without code=7; bubble_err=1 both.
REQ-037 SHALL test: 0x0000 and 0xFFFF back-to-back -> code 0 then 16, consecutive cycles, no errors.
REQ-038 SHALL test: out_ready=0 with 3 words offered -> 2 accepted, in_ready=0, outputs stable; release -> in order.
REQ-039 SHALL test: 300 bubbled words -> err_count=255; clr_err with concurrent error -> 0.
REQ-040 SHALL test: rst_n low with both stages full -> out_valid=0 next cycle, no stale result after release.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared thermometer-code definitions for the decoder and encoder sides.
// Holds the default width, code-width derivation and the result record.
package thermo_pkg;

   localparam int unsigned THERMO_WIDTH = 16;
   localparam int unsigned THERMO_CW    = $clog2(THERMO_WIDTH + 1);

   // Code field is sized for the package default width.
   typedef struct packed {
      logic [THERMO_CW-1:0] code;
      logic                 bubble_err;
   } thermo_result_t;

   function automatic int unsigned thermo_cw(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/thermo_decoder_if.sv
// Stream interface of the thermometer decoder: input word handshake, result
// handshake and error-counter side band.
interface thermo_decoder_if
   import thermo_pkg::*;
#(
   parameter int unsigned WIDTH = THERMO_WIDTH
);

   localparam int unsigned CW = thermo_cw(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] thermo_in;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    code;
   logic             bubble_err;
   logic [7:0]       err_count;
   logic             clr_err;

   modport master (
      output in_valid, thermo_in, out_ready, clr_err,
      input  in_ready, out_valid, code, bubble_err, err_count
   );

   modport slave (
      input  in_valid, thermo_in, out_ready, clr_err,
      output in_ready, out_valid, code, bubble_err, err_count
   );

endinterface

// File: rtl/thermo_bubble_filter.sv
// Combinational bubble detection and, with THERMO_DEC_BUBBLE_FIX_EN defined,
// 3-tap majority correction; otherwise the raw word passes through.
module thermo_bubble_filter #(
   parameter int unsigned WIDTH = thermo_pkg::THERMO_WIDTH
) (
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_word,
   output logic             o_bubble
);

   // Any 0 below a 1 implies at least one adjacent 0->1 step going upward.
   always_comb begin
      o_bubble = 1'b0;
      for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
         o_bubble = o_bubble | (~i_raw[i] & i_raw[i+1]);
      end
   end

`ifdef THERMO_DEC_BUBBLE_FIX_EN
   // w_ext[0] is the virtual raw[-1]=1, w_ext[WIDTH+1] the virtual raw[WIDTH]=0.
   logic [WIDTH+1:0] w_ext;

   assign w_ext = {1'b0, i_raw, 1'b1};

   always_comb begin
      o_word = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         o_word[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) |
                     (w_ext[i+1] & w_ext[i+2]);
      end
   end
`else
   assign o_word = i_raw;
`endif

endmodule

// File: rtl/thermo_decoder.sv
// Two-stage thermometer-to-binary decoder with bubble flagging and a
// saturating error counter. Optional correction: THERMO_DEC_BUBBLE_FIX_EN.
module thermo_decoder
   import thermo_pkg::*;
#(
   parameter int unsigned WIDTH = THERMO_WIDTH
) (
   input logic             clk,
   input logic             rst_n,
   thermo_decoder_if.slave io_bus
);

   localparam int unsigned CW = thermo_cw(WIDTH);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_word;
   logic             r_s1_err;
   logic             r_s2_valid;
   thermo_result_t   r_s2;
   logic [7:0]       r_err_count;

   logic [WIDTH-1:0] w_filtered;
   logic             w_bubble;
   logic             w_s1_ready;
   logic             w_s2_ready;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [CW-1:0]    w_popcount;

   thermo_bubble_filter #(
      .WIDTH (WIDTH)
   ) u_filter (
      .i_raw    (io_bus.thermo_in),
      .o_word   (w_filtered),
      .o_bubble (w_bubble)
   );

   always_comb begin
      w_s2_ready = !r_s2_valid || io_bus.out_ready;
      w_s1_ready = !r_s1_valid || w_s2_ready;
      w_in_fire  = io_bus.in_valid && w_s1_ready;
      w_out_fire = r_s2_valid && io_bus.out_ready;
   end

   always_comb begin
      w_popcount = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_popcount = w_popcount + CW'(r_s1_word[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_word  <= '0;
         r_s1_err   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2       <= '0;
      end else begin
         if (w_s1_ready) begin
            r_s1_valid <= io_bus.in_valid;
            if (w_in_fire) begin
               r_s1_word <= w_filtered;
               r_s1_err  <= w_bubble;
            end
         end
         // S2 only advances when its result is consumed or it is empty.
         if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2.code       <= THERMO_CW'(w_popcount);
               r_s2.bubble_err <= r_s1_err;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || io_bus.clr_err) begin
         r_err_count <= '0;
      end else if (w_out_fire && r_s2.bubble_err && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   // Ready is forced high while in reset so upstream never sees a stall then.
   assign io_bus.in_ready   = !rst_n || w_s1_ready;
   assign io_bus.out_valid  = r_s2_valid;
   assign io_bus.code       = CW'(r_s2.code);
   assign io_bus.bubble_err = r_s2.bubble_err;
   assign io_bus.err_count  = r_err_count;

endmodule

// File: tb/tb_thermo_decoder.sv
// Self-checking bench for thermo_decoder: directed scenarios plus a randomized
// run scored against a level-counting reference model.
`timescale 1ns/1ps
module tb_thermo_decoder;
   import thermo_pkg::*;

   localparam int unsigned W  = THERMO_WIDTH;
   localparam int unsigned CW = thermo_cw(W);

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   thermo_decoder_if #(.WIDTH(W)) u_bus ();

   thermo_decoder #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (u_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   code;
      logic err;
   } exp_t;

   // Number of levels a decoded word reports.
   function automatic int model_code(input logic [W-1:0] raw);
      int n;
`ifdef THERMO_DEC_BUBBLE_FIX_EN
      logic [W+1:0] ext;
      ext = {1'b0, raw, 1'b1};
      n = 0;
      for (int i = 0; i < int'(W); i++) begin
         if (int'(ext[i]) + int'(ext[i+1]) + int'(ext[i+2]) >= 2) n++;
      end
`else
      n = $countones(raw);
`endif
      return n;
   endfunction

   // Clean codes are exactly 2^k-1, i.e. raw & (raw+1) == 0.
   function automatic logic model_err(input logic [W-1:0] raw);
      logic [W-1:0] nxt;
      nxt = raw + 1'b1;
      return (raw & nxt) != '0;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W:0]   t;
      logic [W-1:0] w;
      int           idx;
      t = 1;
      t = t << $urandom_range(0, W);
      t = t - 1;
      w = t[W-1:0];
      if ($urandom_range(0, 1) == 1) begin
         idx    = $urandom_range(0, W - 1);
         w[idx] = ~w[idx];
      end
      return w;
   endfunction

   // One clock: drive, sample just before the edge, return at edge+1.
   task automatic cycle(input logic iv, input logic [W-1:0] w, input logic ordy,
                        input logic clr, output logic acc, output logic ov,
                        output logic [CW-1:0] c, output logic be);
      u_bus.in_valid  = iv;
      u_bus.thermo_in = w;
      u_bus.out_ready = ordy;
      u_bus.clr_err   = clr;
      #1;
      acc = iv && u_bus.in_ready;
      ov  = u_bus.out_valid;
      c   = u_bus.code;
      be  = u_bus.bubble_err;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      u_bus.in_valid  = 1'b0;
      u_bus.thermo_in = '0;
      u_bus.out_ready = 1'b0;
      u_bus.clr_err   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic acc, ov, be;
      logic [CW-1:0] c;
      rst_n           = 1'b0;
      u_bus.in_valid  = 1'b1;
      u_bus.thermo_in = 16'h00FF;
      u_bus.out_ready = 1'b1;
      u_bus.clr_err   = 1'b0;
      #1;
      checks++;
      if (u_bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b expected 1", u_bus.in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (u_bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b expected 0", u_bus.out_valid);
      end
      checks++;
      if (u_bus.code !== '0) begin
         errors++; $display("FAIL reset_code got %0d expected 0", u_bus.code);
      end
      checks++;
      if (u_bus.bubble_err !== 1'b0) begin
         errors++; $display("FAIL reset_bubble got %b expected 0", u_bus.bubble_err);
      end
      checks++;
      if (u_bus.err_count !== 8'd0) begin
         errors++; $display("FAIL reset_err_count got %0d expected 0", u_bus.err_count);
      end
      u_bus.in_valid = 1'b0;
      rst_n          = 1'b1;
      #1;
      checks++;
      if (u_bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_in_ready got %b expected 1", u_bus.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
         checks++;
         if (ov !== 1'b0) begin
            errors++; $display("FAIL reset_no_result cycle %0d got %b expected 0", i, ov);
         end
      end
   endtask

   task automatic test_basic();
      logic acc, ov, be;
      logic [CW-1:0] c;
      do_reset();
      cycle(1'b1, 16'h00FF, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (acc !== 1'b1) begin
         errors++; $display("FAIL basic_accept got %b expected 1", acc);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b0) begin
         errors++; $display("FAIL basic_early_valid got %b expected 0", ov);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b1 || c !== CW'(8) || be !== 1'b0) begin
         errors++;
         $display("FAIL basic_result got v=%b code=%0d err=%b expected v=1 code=8 err=0",
                  ov, c, be);
      end
   endtask

   task automatic test_bubble();
      logic acc, ov, be;
      logic [CW-1:0] c;
      int exp_c;
`ifdef THERMO_DEC_BUBBLE_FIX_EN
      exp_c = 8;
`else
      exp_c = 7;
`endif
      do_reset();
      cycle(1'b1, 16'h00F7, 1'b1, 1'b0, acc, ov, c, be);
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b1 || c !== CW'(exp_c) || be !== 1'b1) begin
         errors++;
         $display("FAIL bubble_result got v=%b code=%0d err=%b expected v=1 code=%0d err=1",
                  ov, c, be, exp_c);
      end
      checks++;
      if (u_bus.err_count !== 8'd1) begin
         errors++; $display("FAIL bubble_err_count got %0d expected 1", u_bus.err_count);
      end
   endtask

   task automatic test_back_to_back();
      logic acc, ov, be;
      logic [CW-1:0] c;
      do_reset();
      cycle(1'b1, 16'h0000, 1'b1, 1'b0, acc, ov, c, be);
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (acc !== 1'b1) begin
         errors++; $display("FAIL b2b_second_accept got %b expected 1", acc);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b1 || c !== CW'(0) || be !== 1'b0) begin
         errors++;
         $display("FAIL b2b_zero got v=%b code=%0d err=%b expected v=1 code=0 err=0", ov, c, be);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b1 || c !== CW'(W) || be !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ones got v=%b code=%0d err=%b expected v=1 code=%0d err=0",
                  ov, c, be, W);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b0 || u_bus.err_count !== 8'd0) begin
         errors++;
         $display("FAIL b2b_tail got v=%b errcnt=%0d expected v=0 errcnt=0", ov, u_bus.err_count);
      end
   endtask

   task automatic test_stall();
      logic acc, ov, be;
      logic [CW-1:0] c;
      logic [W-1:0] words [3];
      int exp_codes [3];
      int accepted;
      words     = '{16'h0001, 16'h0007, 16'h003F};
      exp_codes = '{1, 3, 6};
      accepted  = 0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, words[i], 1'b0, 1'b0, acc, ov, c, be);
         if (acc) accepted++;
      end
      checks++;
      if (accepted != 2) begin
         errors++; $display("FAIL stall_accepted got %0d expected 2", accepted);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, words[2], 1'b0, 1'b0, acc, ov, c, be);
         checks++;
         if (acc !== 1'b0 || ov !== 1'b1 || c !== CW'(exp_codes[0]) || be !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got acc=%b v=%b code=%0d expected 0 1 %0d",
                     i, acc, ov, c, exp_codes[0]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         cycle(i == 0, words[2], 1'b1, 1'b0, acc, ov, c, be);
         checks++;
         if (ov !== 1'b1 || c !== CW'(exp_codes[i])) begin
            errors++;
            $display("FAIL stall_release %0d got v=%b code=%0d expected v=1 code=%0d",
                     i, ov, c, exp_codes[i]);
         end
         if (i == 0) begin
            checks++;
            if (acc !== 1'b1) begin
               errors++; $display("FAIL stall_third_accept got %b expected 1", acc);
            end
         end
      end
   endtask

   task automatic test_random();
      logic acc, ov, be, iv, ordy;
      logic [CW-1:0] c;
      logic [W-1:0] w;
      exp_t q[$];
      exp_t e;
      int   model_cnt;
      model_cnt = 0;
      do_reset();
      for (int n = 0; n < 450; n++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = (n >= 400) || ($urandom_range(0, 3) != 0);
         if (n >= 400) iv = 1'b0;
         w    = rand_word();
         cycle(iv, w, ordy, 1'b0, acc, ov, c, be);
         if (ov && ordy) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_unexpected_result code=%0d at %0d", c, n);
            end else begin
               e = q.pop_front();
               if (c !== CW'(e.code) || be !== e.err) begin
                  errors++;
                  $display("FAIL rand_result at %0d got code=%0d err=%b expected code=%0d err=%b",
                           n, c, be, e.code, e.err);
               end
               if (e.err && model_cnt < 255) model_cnt++;
            end
         end
         if (acc) q.push_back('{code: model_code(w), err: model_err(w)});
         checks++;
         if (u_bus.err_count !== 8'(model_cnt)) begin
            errors++;
            $display("FAIL rand_err_count at %0d got %0d expected %0d", n, u_bus.err_count, model_cnt);
         end
      end
      checks++;
      if (q.size() != 0) begin
         errors++; $display("FAIL rand_drain got %0d pending expected 0", q.size());
      end
   endtask

   task automatic test_err_saturation();
      logic acc, ov, be;
      logic [CW-1:0] c;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         cycle(1'b1, 16'h00F7, 1'b1, 1'b0, acc, ov, c, be);
      end
      repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
      checks++;
      if (u_bus.err_count !== 8'd255) begin
         errors++; $display("FAIL sat_err_count got %0d expected 255", u_bus.err_count);
      end
      cycle(1'b1, 16'h00F7, 1'b0, 1'b0, acc, ov, c, be);
      cycle(1'b0, '0, 1'b0, 1'b0, acc, ov, c, be);
      cycle(1'b0, '0, 1'b1, 1'b1, acc, ov, c, be);
      checks++;
      if (ov !== 1'b1 || be !== 1'b1) begin
         errors++; $display("FAIL clr_concurrent_xfer got v=%b err=%b expected 1 1", ov, be);
      end
      checks++;
      if (u_bus.err_count !== 8'd0) begin
         errors++; $display("FAIL clr_err_count got %0d expected 0", u_bus.err_count);
      end
   endtask

   task automatic test_midflight_reset();
      logic acc, ov, be;
      logic [CW-1:0] c;
      do_reset();
      cycle(1'b1, 16'h000F, 1'b0, 1'b0, acc, ov, c, be);
      cycle(1'b1, 16'h00FF, 1'b0, 1'b0, acc, ov, c, be);
      cycle(1'b0, '0, 1'b0, 1'b0, acc, ov, c, be);
      checks++;
      if (ov !== 1'b1 || u_bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_full got v=%b rdy=%b expected 1 0", ov, u_bus.in_ready);
      end
      rst_n          = 1'b0;
      u_bus.in_valid = 1'b0;
      #1;
      checks++;
      if (u_bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_in_ready got %b expected 1", u_bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (u_bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_out_valid got %b expected 0", u_bus.out_valid);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, acc, ov, c, be);
         checks++;
         if (ov !== 1'b0) begin
            errors++; $display("FAIL midrst_stale cycle %0d got %b expected 0", i, ov);
         end
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      u_bus.in_valid  = 1'b0;
      u_bus.thermo_in = '0;
      u_bus.out_ready = 1'b0;
      u_bus.clr_err   = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_bubble();
      test_back_to_back();
      test_stall();
      test_random();
      test_err_saturation();
      test_midflight_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
